muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide controller that owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU one bit per cycle.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts an operation on a start pulse and holds busy while iterating.
- Stalls dependent MFHI/MFLO or a new mul/div issue until the result is committed.
- Opcode matching uses the `SPECIAL_*` function-code macros from isa_codes.v.

## Interface
- WIDTH, 32, operand and HI/LO width.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- w_start  in  1  issue request, sampled only in IDLE.
- w_op_code_6  in  6  function code: MULT, MULTU, DIV, DIVU, MFHI, MFLO.
- w_input1_x  in  WIDTH  rs operand (multiplicand or dividend).
- w_input2_x  in  WIDTH  rt operand (multiplier or divisor).
- w_kill  in  1  pipeline flush; aborts an operation in flight.
- w_busy  out  1  high whenever the state is not IDLE.
- w_stall  out  1  combinational; high when w_busy and w_op_code_6 is any of the six supported codes.
- w_done  out  1  one-cycle pulse when HI/LO are committed.
- w_div_by_zero  out  1  sticky flag, cleared by the next accepted start.
- w_hi_x  out  WIDTH  HI register (remainder or upper product).
- w_lo_x  out  WIDTH  LO register (quotient or lower product).

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE -> RUN on w_start && !w_kill && op ∈ {MULT, MULTU, DIV, DIVU}.
  - MFHI/MFLO and unknown opcodes never leave IDLE.
  - On accept, latch opcode, sign flags and operand magnitudes.
  - Signed ops take the two's-complement absolute value; unsigned ops use the raw operands.
  - Load cnt = WIDTH-1 and clear w_div_by_zero.
- RUN performs one iteration per edge.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract with remainder and quotient.
  - When cnt == 0, go to FIXUP; otherwise decrement cnt.
- FIXUP writes HI/LO, pulses w_done and returns to IDLE.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops get no fixup.
- Divisor == 0 (DIV or DIVU):
  - Full latency still applies.
  - HI = w_input1_x as latched, LO = all ones, no sign fixup.
  - w_div_by_zero is set in FIXUP.
- Signed DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap.
- w_kill in RUN or FIXUP returns to IDLE at the next edge.
  - HI/LO are unchanged and no w_done is issued.
- w_kill takes priority over w_start in the same cycle; the start is dropped.
- w_start outside IDLE is ignored; nothing is queued.
- Upstream holds the instruction while w_stall is high.

## Timing
- Reset values: state IDLE, w_busy 0, w_done 0, w_div_by_zero 0, HI = LO = 0, cnt 0.
  - Reset is asynchronous and takes effect mid-operation with no commit.
- Accept edge E0 -> RUN for edges E1..E_WIDTH -> FIXUP commits at edge E_{WIDTH+1}.
- w_busy is high for exactly WIDTH+1 cycles (33 for WIDTH = 32).
- w_done is high in the single cycle after E_{WIDTH+1}, which is also the first cycle HI/LO show the new result.
- Back-to-back issue:
  - A new w_start is accepted in the cycle w_done is high, since the state is IDLE.
  - The minimum issue interval is WIDTH+2 cycles.
- MFHI/MFLO presented in the w_done cycle are not stalled and read the new value.
- w_stall is purely combinational from w_busy and w_op_code_6, with zero latency.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF:
  - HI = 0xFFFFFFFE, LO = 0x00000001.
  - w_busy high for 33 cycles; w_done exactly 33 cycles after the accept edge.
- MULT -3 * 7:
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- Division:
  - DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2 -> LO = 3, HI = 1.
  - DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIVU 5 / 0:
  - HI = 5, LO = 0xFFFFFFFF, w_div_by_zero = 1.
  - The next MULTU 2 * 3 clears the flag and gives LO = 6.
- Kill, stall and ignored start:
  - Start MULT 4 * 5 and assert w_kill in RUN cycle 10.
  - Required: w_busy falls next cycle, no w_done, HI/LO hold their previous values.
  - Mid-run MFHI raises w_stall; a w_start mid-run is ignored.
- Reset mid-operation:
  - Pull reset_n low during RUN of DIVU 100 / 7.
  - Required: immediate IDLE, HI = LO = 0, w_busy = 0, no w_done after release.
  - Re-issue after release gives LO = 14, HI = 2.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage and the multi-cycle
// multiply/divide sequencer.
//   master : issues w_start/w_op_code_6/operands/w_kill, observes status and HI/LO
//   slave  : the sequencer side
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             w_start;
    logic [5:0]       w_op_code_6;
    logic [WIDTH-1:0] w_input1_x;
    logic [WIDTH-1:0] w_input2_x;
    logic             w_kill;
    logic             w_busy;
    logic             w_stall;
    logic             w_done;
    logic             w_div_by_zero;
    logic [WIDTH-1:0] w_hi_x;
    logic [WIDTH-1:0] w_lo_x;

    modport master (
        output w_start, w_op_code_6, w_input1_x, w_input2_x, w_kill,
        input  w_busy, w_stall, w_done, w_div_by_zero, w_hi_x, w_lo_x
    );

    modport slave (
        input  w_start, w_op_code_6, w_input1_x, w_input2_x, w_kill,
        output w_busy, w_stall, w_done, w_div_by_zero, w_hi_x, w_lo_x
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// One iteration per clock: shift-add multiply, restoring divide.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : w_start/w_op_code_6/w_input1_x/w_input2_x/w_kill in;
//                    w_busy/w_stall/w_done/w_div_by_zero/w_hi_x/w_lo_x out
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    muldiv_sequencer_if.slave  bus
);
    // SPECIAL function codes (isa_codes.v values)
    localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
    localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
    localparam logic [5:0] SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
    localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;   // operand signs differ (signed ops only)
    logic               neg_rem;   // dividend negative (signed ops only)
    logic [WIDTH-1:0]   a_raw;     // dividend as issued, returned on divide-by-zero
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   hi, lo;
    logic               done, dbz;

    logic               op_mul_div, op_mf, op_signed, op_div, accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_next, prod_neg;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        op_mul_div = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_MULTU) ||
                     (bus.w_op_code_6 == SPECIAL_DIV)  || (bus.w_op_code_6 == SPECIAL_DIVU);
        op_mf      = (bus.w_op_code_6 == SPECIAL_MFHI) || (bus.w_op_code_6 == SPECIAL_MFLO);
        op_signed  = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_DIV);
        op_div     = (bus.w_op_code_6 == SPECIAL_DIV)  || (bus.w_op_code_6 == SPECIAL_DIVU);
        accept     = (state == IDLE) && bus.w_start && !bus.w_kill && op_mul_div;

        a_neg = op_signed && bus.w_input1_x[WIDTH-1];
        b_neg = op_signed && bus.w_input2_x[WIDTH-1];
        a_abs = a_neg ? -bus.w_input1_x : bus.w_input1_x;
        b_abs = b_neg ? -bus.w_input2_x : bus.w_input2_x;

        // Multiply step: conditionally add into the upper half, then shift right.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        // Divide step: shift next dividend bit into the remainder, trial subtract.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};

        if (is_div)
            acc_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};

        prod_neg = -acc;
        quot     = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_raw   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        cnt     <= CW'(WIDTH - 1);
                        is_div  <= op_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        a_raw   <= bus.w_input1_x;
                        b_mag   <= b_abs;
                        acc     <= {{WIDTH{1'b0}}, a_abs};
                        dbz     <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.w_kill) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        if (cnt == '0) state <= FIXUP;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!bus.w_kill) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= neg_res ? prod_neg : acc;
                        end else if (b_mag == '0) begin
                            // divide-by-zero: dividend back in HI, all ones in LO
                            hi  <= a_raw;
                            lo  <= '1;
                            dbz <= 1'b1;
                        end else begin
                            lo <= neg_res ? -quot : quot;
                            hi <= neg_rem ? -rem  : rem;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.w_busy        = (state != IDLE);
    assign bus.w_stall       = (state != IDLE) && (op_mul_div || op_mf);
    assign bus.w_done        = done;
    assign bus.w_div_by_zero = dbz;
    assign bus.w_hi_x        = hi;
    assign bus.w_lo_x        = lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
    localparam logic [5:0] OP_BAD   = 6'h20;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   lat, bcnt;
    logic saw_done;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs and samples both sit 1 time unit after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // issue an op and wait (bounded) for w_done; lat = edges after accept
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int latency, output int busy_cycles);
        bus.w_op_code_6 = op;
        bus.w_input1_x  = a;
        bus.w_input2_x  = b;
        bus.w_start     = 1'b1;
        step();
        bus.w_start = 1'b0;
        busy_cycles = bus.w_busy ? 1 : 0;
        latency = 0;
        while (!bus.w_done && latency < 100) begin
            step();
            latency++;
            if (bus.w_busy) busy_cycles++;
        end
    endtask

    initial begin
        bus.w_start     = 1'b0;
        bus.w_op_code_6 = OP_BAD;
        bus.w_input1_x  = '0;
        bus.w_input2_x  = '0;
        bus.w_kill      = 1'b0;
        reset_n         = 1'b0;
        step();
        step();

        // reset state
        check("rst_busy", 32'(bus.w_busy), 32'd0);
        check("rst_done", 32'(bus.w_done), 32'd0);
        check("rst_dbz",  32'(bus.w_div_by_zero), 32'd0);
        check("rst_hi",   bus.w_hi_x, 32'h0);
        check("rst_lo",   bus.w_lo_x, 32'h0);
        reset_n = 1'b1;
        step();

        // MFHI / unknown opcodes never leave IDLE; stall low while idle
        bus.w_op_code_6 = OP_MFHI;
        bus.w_start = 1'b1;
        step();
        check("mfhi_no_issue", 32'(bus.w_busy), 32'd0);
        bus.w_op_code_6 = OP_BAD;
        step();
        check("bad_no_issue", 32'(bus.w_busy), 32'd0);
        bus.w_op_code_6 = OP_MULT;
        #1;
        check("idle_no_stall", 32'(bus.w_stall), 32'd0);
        bus.w_start = 1'b0;

        // kill beats start in IDLE
        bus.w_op_code_6 = OP_MULTU;
        bus.w_start = 1'b1;
        bus.w_kill  = 1'b1;
        step();
        bus.w_start = 1'b0;
        bus.w_kill  = 1'b0;
        check("kill_beats_start", 32'(bus.w_busy), 32'd0);

        // MULTU max * max, latency and busy length
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_lat",  32'(lat),  32'd33);
        check("multu_busy", 32'(bcnt), 32'd33);
        check("multu_hi", bus.w_hi_x, 32'hFFFF_FFFE);
        check("multu_lo", bus.w_lo_x, 32'h0000_0001);
        bus.w_op_code_6 = OP_MFHI;
        #1;
        check("mfhi_done_no_stall", 32'(bus.w_stall), 32'd0);
        step();
        check("done_one_cycle", 32'(bus.w_done), 32'd0);

        // MULT -3 * 7
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        check("mult_lat", 32'(lat), 32'd33);
        check("mult_hi", bus.w_hi_x, 32'hFFFF_FFFF);
        check("mult_lo", bus.w_lo_x, 32'hFFFF_FFEB);

        // back-to-back: issue in the done cycle
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_lat", 32'(lat), 32'd33);
        check("div_lo", bus.w_lo_x, 32'hFFFF_FFFD);
        check("div_hi", bus.w_hi_x, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd7, 32'd2, lat, bcnt);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_lo", bus.w_lo_x, 32'd3);
        check("divu_hi", bus.w_hi_x, 32'd1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("divovf_lo", bus.w_lo_x, 32'h8000_0000);
        check("divovf_hi", bus.w_hi_x, 32'h0);

        // divide by zero
        run_op(OP_DIVU, 32'd5, 32'd0, lat, bcnt);
        check("dbz_lat", 32'(lat), 32'd33);
        check("dbz_hi", bus.w_hi_x, 32'd5);
        check("dbz_lo", bus.w_lo_x, 32'hFFFF_FFFF);
        check("dbz_flag", 32'(bus.w_div_by_zero), 32'd1);
        step();
        step();
        check("dbz_sticky", 32'(bus.w_div_by_zero), 32'd1);

        // next start clears the flag
        bus.w_op_code_6 = OP_MULTU;
        bus.w_input1_x  = 32'd2;
        bus.w_input2_x  = 32'd3;
        bus.w_start     = 1'b1;
        step();
        bus.w_start = 1'b0;
        check("dbz_cleared", 32'(bus.w_div_by_zero), 32'd0);
        lat = 0;
        while (!bus.w_done && lat < 100) begin
            step();
            lat++;
        end
        check("multu6_lat", 32'(lat), 32'd33);
        check("multu6_lo", bus.w_lo_x, 32'd6);
        check("multu6_hi", bus.w_hi_x, 32'd0);
        step();

        // kill mid-run, stall and ignored start
        bus.w_op_code_6 = OP_MULT;
        bus.w_input1_x  = 32'd4;
        bus.w_input2_x  = 32'd5;
        bus.w_start     = 1'b1;
        step();
        bus.w_start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        bus.w_op_code_6 = OP_MFHI;
        #1;
        check("run_stall_mfhi", 32'(bus.w_stall), 32'd1);
        bus.w_op_code_6 = OP_BAD;
        #1;
        check("run_no_stall_bad", 32'(bus.w_stall), 32'd0);
        bus.w_op_code_6 = OP_MULTU;
        bus.w_input1_x  = 32'd9;
        bus.w_input2_x  = 32'd9;
        bus.w_start     = 1'b1;
        step();
        bus.w_start = 1'b0;
        check("run_start_ignored_busy", 32'(bus.w_busy), 32'd1);
        bus.w_kill = 1'b1;
        step();
        bus.w_kill = 1'b0;
        check("kill_busy", 32'(bus.w_busy), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.w_done || bus.w_busy) saw_done = 1'b1;
        end
        check("kill_no_done", 32'(saw_done), 32'd0);
        check("kill_hi", bus.w_hi_x, 32'd0);
        check("kill_lo", bus.w_lo_x, 32'd6);

        // asynchronous reset mid-operation
        bus.w_op_code_6 = OP_DIVU;
        bus.w_input1_x  = 32'd100;
        bus.w_input2_x  = 32'd7;
        bus.w_start     = 1'b1;
        step();
        bus.w_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_busy", 32'(bus.w_busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.w_busy), 32'd0);
        check("arst_hi", bus.w_hi_x, 32'd0);
        check("arst_lo", bus.w_lo_x, 32'd0);
        step();
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.w_done) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);

        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        check("reissue_lat", 32'(lat), 32'd33);
        check("reissue_lo", bus.w_lo_x, 32'd14);
        check("reissue_hi", bus.w_hi_x, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
